// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port block RAM between num_req requesters. A round-robin
// arbiter picks at most one requester per cycle. The accepted command is
// registered onto the RAM port, and read completions are strobed back two
// cycles after acceptance. Back-to-back acceptance is supported every cycle.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset     : synchronous active-high reset
//   req       : per-requester request, held with its fields until ack
//   req_wr    : per-requester command type (1 = write, 0 = read)
//   req_addr  : packed per-requester addresses, [i*address_width +: address_width]
//   req_din   : packed per-requester write data, [i*data_width +: data_width]
//   ack       : one-hot-or-zero acceptance, combinational
//   rvalid    : one-hot-or-zero read-data strobe, two cycles after acceptance
//   rdata     : shared read data (ram_dout passed through)
//   ram_wr    : registered RAM write enable
//   ram_addr  : registered RAM address
//   ram_din   : registered RAM write data
//   ram_dout  : RAM read data, valid the cycle after the address is sampled
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int data_width    = 72,
    parameter int address_width = 10,
    parameter int num_req       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [num_req-1:0]                 req,
    input  logic [num_req-1:0]                 req_wr,
    input  logic [num_req*address_width-1:0]   req_addr,
    input  logic [num_req*data_width-1:0]      req_din,
    output logic [num_req-1:0]                 ack,
    output logic [num_req-1:0]                 rvalid,
    output logic [data_width-1:0]              rdata,
    output logic                               ram_wr,
    output logic [address_width-1:0]           ram_addr,
    output logic [data_width-1:0]              ram_din,
    input  logic [data_width-1:0]              ram_dout
);

    localparam int              IDX_W    = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_req - 1);

    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         cand;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_found;
    logic                     xfer;

    logic                     sel_wr;
    logic [address_width-1:0] sel_addr;
    logic [data_width-1:0]    sel_din;

    logic                     ram_wr_p1;
    logic [address_width-1:0] ram_addr_p1;
    logic [data_width-1:0]    ram_din_p1;
    logic                     vld_p1;
    logic [IDX_W-1:0]         rd_id_p1;

    logic                     vld_p2;
    logic [IDX_W-1:0]         rd_id_p2;

    // Round-robin search: walk forward from the requester after last_grant,
    // wrapping at num_req-1, and take the first active request.
    always_comb begin
        cand        = last_grant;
        grant_found = 1'b0;
        grant_idx   = last_grant;
        for (int k = 0; k < num_req; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign xfer = grant_found && !reset;

    // Fetch the winning requester's command fields.
    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < num_req; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_wr   = req_wr[i];
                sel_addr = req_addr[i*address_width +: address_width];
                sel_din  = req_din[i*data_width +: data_width];
            end
        end
    end

    always_comb begin
        ack    = '0;
        rvalid = '0;
        for (int i = 0; i < num_req; i++) begin
            ack[i]    = xfer && (grant_idx == IDX_W'(i));
            rvalid[i] = vld_p2 && (rd_id_p2 == IDX_W'(i));
        end
    end

    // ---- stage 1: arbitration state and RAM-port command register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= LAST_IDX;
            ram_wr_p1   <= 1'b0;
            ram_addr_p1 <= '0;
            ram_din_p1  <= '0;
            vld_p1      <= 1'b0;
            rd_id_p1    <= '0;
        end else if (xfer) begin
            last_grant  <= grant_idx;
            ram_wr_p1   <= sel_wr;
            ram_addr_p1 <= sel_addr;
            ram_din_p1  <= sel_din;
            vld_p1      <= !sel_wr;
            rd_id_p1    <= grant_idx;
        end else begin
            // Idle cycle: no write, address/data hold to avoid RAM toggling.
            ram_wr_p1   <= 1'b0;
            vld_p1      <= 1'b0;
        end
    end

    // ---- stage 2: pending read-valid, aligned with ram_dout ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2   <= 1'b0;
            rd_id_p2 <= '0;
        end else begin
            vld_p2   <= vld_p1;
            rd_id_p2 <= rd_id_p1;
        end
    end

    assign ram_wr   = ram_wr_p1;
    assign ram_addr = ram_addr_p1;
    assign ram_din  = ram_din_p1;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

    localparam int DW = 72;
    localparam int AW = 10;
    localparam int NR = 4;

    logic               clk;
    logic               reset;
    logic [NR-1:0]      req;
    logic [NR-1:0]      req_wr;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_din;
    logic [NR-1:0]      ack;
    logic [NR-1:0]      rvalid;
    logic [DW-1:0]      rdata;
    logic               ram_wr;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic [DW-1:0]      ram_dout;

    logic [DW-1:0]      mem [0:(1<<AW)-1];

    int n_cmp;
    int n_err;

    bram_port_arbiter #(
        .data_width   (DW),
        .address_width(AW),
        .num_req      (NR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_wr  (req_wr),
        .req_addr(req_addr),
        .req_din (req_din),
        .ack     (ack),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .ram_wr  (ram_wr),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return {8'h5A, 32'(a), 32'(a * 7 + 3)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]           = wr;
        req_addr[i*AW +: AW] = a;
        req_din[i*DW +: DW]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] r, input int lg);
        logic [NR-1:0] g;
        g = '0;
        for (int k = 1; k <= NR; k++) begin
            if (g == '0 && r[(lg + k) % NR]) g[(lg + k) % NR] = 1'b1;
        end
        return g;
    endfunction

    initial begin
        logic [NR-1:0] exp_ack;
        logic [NR-1:0] exp_rv;
        logic [NR-1:0] pend;
        int            lg;
        int            waitc [NR];
        int            maxw;

        n_cmp = 0;
        n_err = 0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(a);
        ram_dout = '0;
        reset    = 1'b1;
        req      = '0;
        req_wr   = '0;
        req_addr = '0;
        req_din  = '0;

        // Reset state; all requests active must not be acked during reset.
        next_cycle();
        next_cycle();
        for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, AW'(16 + i), '0);
        req = 4'b1111;
        @(negedge clk);
        chk("reset_ack", DW'(ack), DW'(0));
        chk("reset_ram_wr", DW'(ram_wr), DW'(0));
        chk("reset_ram_addr", DW'(ram_addr), DW'(0));
        chk("reset_ram_din", ram_din, DW'(0));
        chk("reset_rvalid", DW'(rvalid), DW'(0));
        next_cycle();
        reset = 1'b0;

        // All four requesters reading: rotating acks, rvalid two cycles behind.
        for (int k = 0; k < 7; k++) begin
            if (k == 5) req = '0;
            @(negedge clk);
            exp_ack = (k < 5) ? 4'(1 << (k % 4)) : 4'b0000;
            exp_rv  = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
            chk($sformatf("rr_ack_%0d", k), DW'(ack), DW'(exp_ack));
            chk($sformatf("rr_rvalid_%0d", k), DW'(rvalid), DW'(exp_rv));
            if (k >= 2) chk($sformatf("rr_rdata_%0d", k), rdata, init_val(16 + (k - 2) % 4));
            if (k == 1) chk("rr_ram_addr", DW'(ram_addr), DW'(16));
            next_cycle();
        end
        // last_grant is now 0.

        // Write by requester 2 then read of same address by requester 1.
        set_cmd(2, 1'b1, 10'h005, 72'hA5);
        req = 4'b0100;
        @(negedge clk);
        chk("wr_ack", DW'(ack), DW'(4'b0100));
        next_cycle();
        set_cmd(2, 1'b0, 10'h000, '0);
        set_cmd(1, 1'b0, 10'h005, '0);
        req = 4'b0010;
        @(negedge clk);
        chk("rd_ack", DW'(ack), DW'(4'b0010));
        chk("wr_ram_wr", DW'(ram_wr), DW'(1));
        chk("wr_ram_addr", DW'(ram_addr), DW'(10'h005));
        chk("wr_ram_din", ram_din, 72'hA5);
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("rd_ram_wr", DW'(ram_wr), DW'(0));
        chk("wr_no_rvalid", DW'(rvalid), DW'(0));
        next_cycle();
        @(negedge clk);
        chk("raw_rvalid", DW'(rvalid), DW'(4'b0010));
        chk("raw_rdata", rdata, 72'hA5);
        next_cycle();

        // Requester 3 alone for six cycles.
        for (int k = 0; k < 8; k++) begin
            req = (k < 6) ? 4'b1000 : 4'b0000;
            set_cmd(3, 1'b0, AW'(32 + k), '0);
            @(negedge clk);
            chk($sformatf("solo_ack_%0d", k), DW'(ack), DW'((k < 6) ? 4'b1000 : 4'b0000));
            chk($sformatf("solo_rvalid_%0d", k), DW'(rvalid), DW'((k >= 2) ? 4'b1000 : 4'b0000));
            if (k >= 2) chk($sformatf("solo_rdata_%0d", k), rdata, init_val(32 + k - 2));
            next_cycle();
        end
        req = '0;
        next_cycle();

        // Make last_grant = 0, then requesters 0 and 1 together.
        set_cmd(0, 1'b0, 10'h040, '0);
        set_cmd(1, 1'b0, 10'h041, '0);
        req = 4'b0001;
        @(negedge clk);
        chk("lg0_ack", DW'(ack), DW'(4'b0001));
        next_cycle();
        req = 4'b0011;
        @(negedge clk);
        chk("pair_ack_first", DW'(ack), DW'(4'b0010));
        next_cycle();
        @(negedge clk);
        chk("pair_ack_second", DW'(ack), DW'(4'b0001));
        next_cycle();

        // Random pending requests, held until acked; check grants and wait bound.
        lg   = 0;
        pend = '0;
        maxw = 0;
        for (int i = 0; i < NR; i++) waitc[i] = 0;
        for (int c = 0; c < 100; c++) begin
            pend = pend | 4'($urandom_range(0, 15));
            req  = pend;
            for (int i = 0; i < NR; i++) set_cmd(i, 1'b0, AW'($urandom_range(0, 1023)), '0);
            @(negedge clk);
            exp_ack = rr_pick(pend, lg);
            chk($sformatf("rand_ack_%0d", c), DW'(ack), DW'(exp_ack));
            for (int i = 0; i < NR; i++) begin
                if (exp_ack[i]) begin
                    if (waitc[i] > maxw) maxw = waitc[i];
                    waitc[i] = 0;
                    lg = i;
                end else if (pend[i]) begin
                    waitc[i]++;
                end
            end
            pend = pend & ~exp_ack;
            next_cycle();
        end
        chk("max_wait_lt_num_req", DW'(maxw < NR), DW'(1));
        req = '0;
        for (int k = 0; k < 3; k++) next_cycle();

        // Read accepted, then reset the next cycle: nothing must come out.
        set_cmd(0, 1'b0, 10'h030, '0);
        req = 4'b0001;
        @(negedge clk);
        chk("rst_rd_ack", DW'(ack), DW'(4'b0001));
        next_cycle();
        reset = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        chk("rst_mid_ack", DW'(ack), DW'(0));
        chk("rst_mid_ram_wr", DW'(ram_wr), DW'(0));
        next_cycle();
        reset = 1'b0;
        set_cmd(0, 1'b0, 10'h011, '0);
        set_cmd(3, 1'b0, 10'h013, '0);
        req = 4'b1001;
        @(negedge clk);
        chk("post_rst_rvalid", DW'(rvalid), DW'(0));
        chk("post_rst_ram_wr", DW'(ram_wr), DW'(0));
        chk("post_rst_ram_addr", DW'(ram_addr), DW'(0));
        chk("post_rst_ack", DW'(ack), DW'(4'b0001));
        next_cycle();
        req = 4'b1000;
        @(negedge clk);
        chk("post_rst_ack2", DW'(ack), DW'(4'b1000));
        chk("post_rst_rvalid2", DW'(rvalid), DW'(0));
        chk("post_rst_ram_addr2", DW'(ram_addr), DW'(10'h011));
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("post_rst_rvalid3", DW'(rvalid), DW'(4'b0001));
        chk("post_rst_rdata3", rdata, init_val(16'h011));
        next_cycle();
        @(negedge clk);
        chk("post_rst_rvalid4", DW'(rvalid), DW'(4'b1000));
        chk("post_rst_rdata4", rdata, init_val(16'h013));
        next_cycle();

        // Requester 1 loses to requester 0, then drops its request.
        set_cmd(0, 1'b0, 10'h050, '0);
        set_cmd(1, 1'b0, 10'h051, '0);
        req = 4'b0011;
        @(negedge clk);
        chk("drop_ack_a", DW'(ack), DW'(4'b0001));
        next_cycle();
        req = '0;
        @(negedge clk);
        chk("drop_ack_b", DW'(ack), DW'(0));
        chk("drop_ram_addr", DW'(ram_addr), DW'(10'h050));
        next_cycle();
        @(negedge clk);
        chk("drop_rvalid_c", DW'(rvalid), DW'(4'b0001));
        next_cycle();
        @(negedge clk);
        chk("drop_rvalid_d", DW'(rvalid), DW'(0));
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter data_width, default 72, width of the RAM data word.
REQ-002 Parameter address_width, default 10, width of the RAM address.
REQ-003 Parameter num_req, default 4, number of requesters sharing one RAM port; legal range 2..8.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 req  input  num_req  per-requester access request; held with its command fields until accepted.
REQ-007 req_wr  input  num_req  per-requester command type: 1 = write, 0 = read.
REQ-008 req_addr  input  num_req*address_width  per-requester address; requester i occupies slice [i*address_width +: address_width].
REQ-009 req_din  input  num_req*data_width  per-requester write data; requester i occupies slice [i*data_width +: data_width].
REQ-010 ack  output  num_req  one-hot-or-zero acceptance; combinational in the accepting cycle.
REQ-011 rvalid  output  num_req  one-hot-or-zero read-data-valid strobe, one cycle per accepted read.
REQ-012 rdata  output  data_width  read data, shared by all requesters and qualified by rvalid.
REQ-013 ram_wr  output  1  registered write enable to the RAM port.
REQ-014 ram_addr  output  address_width  registered address to the RAM port.
REQ-015 ram_din  output  data_width  registered write data to the RAM port.
REQ-016 ram_dout  input  data_width  RAM port read output; valid the cycle after the RAM samples an address.

Function
REQ-017 A transfer on requester i occurs in any cycle where req[i] and ack[i] are both 1; at most one ack bit is 1 per cycle.
REQ-018 ack is 0 for every requester whose req is 0, and ack is all-zero while reset is 1.
REQ-019 Arbitration is round-robin:
- search starts at requester (last_grant+1) mod num_req and wraps;
- the first requester found with req=1 wins.
REQ-020 last_grant updates only in cycles with a transfer; with no transfer it holds.
REQ-021 A requester holding req continuously is granted within num_req cycles.
REQ-022 On a transfer in cycle T, the accepted command drives the RAM port during cycle T+1:
- ram_addr = accepted address;
- ram_din = accepted write data;
- ram_wr = accepted req_wr.
REQ-023 In cycles with no transfer, ram_wr is 0 in the following cycle; ram_addr and ram_din hold their last values.
REQ-024 An accepted read in cycle T produces rvalid[i]=1 in cycle T+2 only, with rdata = ram_dout in that cycle (rdata passes ram_dout through combinationally).
REQ-025 An accepted write produces no rvalid pulse.
REQ-026 The block accepts back-to-back transfers every cycle.
- The pipeline holds up to 2 commands in flight: stage 1 is the RAM-port register, stage 2 is the pending-rvalid register.
- rvalid ordering equals acceptance ordering.
REQ-027 Requester change between consecutive cycles is allowed with no bubble.
REQ-028 A requester may drop req before ack; no transfer and no side effect result.
REQ-029 A write to address X accepted in cycle T, followed by a read of X accepted in T+1, returns the new data at T+3. This relies on the RAM port completing the write at the end of T+1.

Reset
REQ-030 With reset=1 at a rising edge, the following values are set:
- ram_wr=0, ram_addr=0, ram_din=0;
- rvalid=0 and all in-flight pipeline stages cleared;
- last_grant=num_req-1, so requester 0 has first priority.
REQ-031 Reset mid-operation discards in-flight commands. No rvalid pulse is produced for reads accepted before reset, and a stage-1 write is not issued after reset.
REQ-032 The first transfer is possible in the first cycle with reset=0.

Verification
REQ-033 Reset then req=4'b1111, all reads -> ack sequence 0001,0010,0100,1000,0001 on consecutive cycles; rvalid follows two cycles behind each ack.
REQ-034 Requester 2 writes addr 0x005 data 0xA5 (cycle T), requester 1 reads addr 0x005 (T+1) -> ram_wr=1 in T+1, rvalid=0010 in T+3 with rdata=0xA5.
REQ-035 Only requester 3 holding req for 6 cycles -> ack[3]=1 every cycle; 6 consecutive rvalid[3] pulses start at cycle +2.
REQ-036 req=0011 after last_grant=0 -> ack=0010 first, then 0001; check no starvation over 100 random cycles (max wait < num_req).
REQ-037 Read accepted at T, reset=1 at T+1 -> rvalid stays 0 at T+2 and ram_wr=0 throughout; ack=0 during reset.
REQ-038 Requester raises req for one cycle while another wins, then drops it -> no ack and no rvalid for the dropped requester.
